// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the set-associative instruction cache.
package icache_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_MISS_REQ,
        ST_REFILL,
        ST_RESP
    } state_e;

    localparam logic [31:0] KSEG1_BASE = 32'hA000_0000;
    localparam logic [31:0] KSEG1_MASK = 32'hE000_0000;

    function automatic int unsigned offset_w(input int unsigned line_words);
        return $clog2(line_words) + 2;
    endfunction

    function automatic int unsigned index_w(input int unsigned sets);
        return $clog2(sets);
    endfunction

    function automatic int unsigned tag_w(input int unsigned line_words, input int unsigned sets);
        return 32 - offset_w(line_words) - index_w(sets);
    endfunction

endpackage

// File: rtl/icache_way_ram.sv
// One cache way: tag/valid/data arrays, word-granular refill write, registered read.
module icache_way_ram
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SETS       = 64,
    localparam int unsigned WORD_W    = offset_w(LINE_WORDS) - 2,
    localparam int unsigned INDEX_W   = index_w(SETS),
    localparam int unsigned TAG_W     = tag_w(LINE_WORDS, SETS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_index,
    input  logic [WORD_W-1:0]  i_rd_word,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic               o_rd_valid,
    output logic [31:0]        o_rd_data,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_index,
    input  logic [WORD_W-1:0]  i_wr_word,
    input  logic [31:0]        i_wr_data,
    input  logic               i_tag_we,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic               i_vld_clr
);

    logic [31:0]      r_data [SETS*LINE_WORDS];
    logic [TAG_W-1:0] r_tag  [SETS];
    logic [SETS-1:0]  r_valid;

    // Storage arrays carry no reset; only the valid bits do.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[{i_wr_index, i_wr_word}] <= i_wr_data;
        end
        if (i_tag_we) begin
            r_tag[i_wr_index] <= i_wr_tag;
        end
        o_rd_data <= r_data[{i_rd_index, i_rd_word}];
        o_rd_tag  <= r_tag[i_rd_index];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= '0;
            o_rd_valid <= 1'b0;
        end else begin
            if (i_vld_clr) begin
                r_valid[i_wr_index] <= 1'b0;
            end
            if (i_tag_we) begin
                r_valid[i_wr_index] <= 1'b1;
            end
            o_rd_valid <= r_valid[i_rd_index];
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache with round-robin refill and uncached bypass.
// Optional ICACHE_UNCACHED_EN: kseg1 (0xA000_0000-0xBFFF_FFFF) bypasses the cache.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 8,
    parameter int unsigned SETS       = 64,
    parameter int unsigned WAYS       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cache_ena,
    input  logic        flush,
    input  logic [31:0] s_araddr,
    input  logic        s_arvalid,
    output logic [31:0] s_rdata,
    output logic        s_rvalid,
    output logic [31:0] m_araddr,
    output logic        m_arvalid,
    input  logic        m_arready,
    input  logic [31:0] m_rdata,
    input  logic        m_rvalid,
    input  logic        m_rlast,
    output logic        m_rready
);

    localparam int unsigned OFFSET_W = offset_w(LINE_WORDS);
    localparam int unsigned WORD_W   = OFFSET_W - 2;
    localparam int unsigned INDEX_W  = index_w(SETS);
    localparam int unsigned TAG_W    = tag_w(LINE_WORDS, SETS);
    localparam int unsigned WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned BEAT_W   = WORD_W + 1;

    state_e            r_state;
    logic [31:0]       r_addr;
    logic [31:0]       r_data;
    logic              r_unc;
    logic              r_flushed;
    logic [BEAT_W-1:0] r_beat;
    logic [WAY_W-1:0]  r_victim;
    logic [WAY_W-1:0]  r_rr [SETS];

    logic [TAG_W-1:0]   w_rd_tag  [WAYS];
    logic [31:0]        w_rd_data [WAYS];
    logic [WAYS-1:0]    w_rd_valid;
    logic [INDEX_W-1:0] w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic [WORD_W-1:0]  w_word;
    logic               w_unc;
    logic               w_hit;
    logic [31:0]        w_hit_data;
    logic [WAY_W-1:0]   w_victim;
    logic               w_beat_req;
    logic               w_wr_en;
    logic               w_install;
    logic               w_vld_clr;

    assign w_idx  = r_addr[OFFSET_W+INDEX_W-1:OFFSET_W];
    assign w_tag  = r_addr[31:OFFSET_W+INDEX_W];
    assign w_word = r_addr[OFFSET_W-1:2];

    always_comb begin
        w_unc = !cache_ena;
`ifdef ICACHE_UNCACHED_EN
        if ((s_araddr & KSEG1_MASK) == KSEG1_BASE) begin
            w_unc = 1'b1;
        end
`endif
    end

    // Tag compare and victim pick; descending loop leaves the lowest invalid way.
    always_comb begin
        w_hit      = 1'b0;
        w_hit_data = '0;
        w_victim   = r_rr[w_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_rd_valid[w] && (w_rd_tag[w] == w_tag)) begin
                w_hit      = 1'b1;
                w_hit_data = w_rd_data[w];
            end
            if (!w_rd_valid[w]) begin
                w_victim = WAY_W'(w);
            end
        end
    end

    assign w_beat_req = r_unc ? (r_beat == '0) : (r_beat == BEAT_W'(w_word));
    assign w_wr_en    = (r_state == ST_REFILL) && m_rvalid && !r_unc
                        && (r_beat < BEAT_W'(LINE_WORDS));
    assign w_install  = (r_state == ST_REFILL) && m_rvalid && m_rlast && !r_unc
                        && (r_beat == BEAT_W'(LINE_WORDS - 1));
    assign w_vld_clr  = (r_state == ST_MISS_REQ) && m_arready && !r_unc;

    for (genvar g = 0; g < WAYS; g++) begin : g_way
        icache_way_ram #(
            .LINE_WORDS (LINE_WORDS),
            .SETS       (SETS)
        ) u_ram (
            .clk        (clk),
            .rst        (rst),
            .i_rd_index (s_araddr[OFFSET_W+INDEX_W-1:OFFSET_W]),
            .i_rd_word  (s_araddr[OFFSET_W-1:2]),
            .o_rd_tag   (w_rd_tag[g]),
            .o_rd_valid (w_rd_valid[g]),
            .o_rd_data  (w_rd_data[g]),
            .i_wr_en    (w_wr_en && (r_victim == WAY_W'(g))),
            .i_wr_index (w_idx),
            .i_wr_word  (r_beat[WORD_W-1:0]),
            .i_wr_data  (m_rdata),
            .i_tag_we   (w_install && (r_victim == WAY_W'(g))),
            .i_wr_tag   (w_tag),
            .i_vld_clr  (w_vld_clr && (r_victim == WAY_W'(g)))
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            m_arvalid <= 1'b0;
            m_araddr  <= '0;
            m_rready  <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
            r_unc     <= 1'b0;
            r_flushed <= 1'b0;
            r_beat    <= '0;
            r_victim  <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
            end
        end else begin
            s_rvalid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (s_arvalid && !flush) begin
                        r_addr  <= s_araddr;
                        r_unc   <= w_unc;
                        r_state <= ST_LOOKUP;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_LOOKUP: begin
                    if (flush) begin
                        r_state <= ST_IDLE;
                    end else if (w_hit && !r_unc) begin
                        s_rvalid <= 1'b1;
                        s_rdata  <= w_hit_data;
                        r_state  <= ST_IDLE;
                    end else begin
                        m_arvalid <= 1'b1;
                        m_araddr  <= r_unc ? r_addr : {r_addr[31:OFFSET_W], OFFSET_W'(0)};
                        r_victim  <= w_victim;
                        r_beat    <= '0;
                        r_flushed <= 1'b0;
                        r_state   <= ST_MISS_REQ;
                    end
                end
                ST_MISS_REQ: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (m_arready) begin
                        m_arvalid <= 1'b0;
                        m_rready  <= 1'b1;
                        r_state   <= ST_REFILL;
                    end
                end
                ST_REFILL: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    if (m_rvalid) begin
                        if (w_beat_req) begin
                            r_data <= m_rdata;
                        end
                        // Saturate so an overlong burst can never look complete.
                        if (r_beat != BEAT_W'(LINE_WORDS)) begin
                            r_beat <= r_beat + 1'b1;
                        end
                        if (m_rlast) begin
                            m_rready <= 1'b0;
                            if (w_install) begin
                                r_rr[w_idx] <= (WAYS == 1) ? '0 : r_rr[w_idx] + 1'b1;
                            end
                            if (flush || r_flushed) begin
                                r_state <= ST_IDLE;
                            end else begin
                                s_rvalid <= 1'b1;
                                s_rdata  <= w_beat_req ? m_rdata : r_data;
                                r_state  <= ST_RESP;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Scoreboard bench for icache_assoc: memory model returns the byte address as data.
module tb_icache_assoc;

    localparam int LINE_WORDS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cache_ena;
    logic        flush;
    logic [31:0] s_araddr;
    logic        s_arvalid;
    logic [31:0] s_rdata;
    logic        s_rvalid;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic        m_rvalid;
    logic        m_rlast;
    logic        m_rready;

    typedef struct {
        logic [31:0] data;
        int          exp_cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        int          beats;
    } mem_t;

    rsp_t rsp_q[$];
    mem_t mem_q[$];
    int   cmp_cnt   = 0;
    int   err_cnt   = 0;
    int   cyc       = 0;
    int   rlast_cyc = -100;
    int   mem_beat  = -1;

    rsp_t        mon_r;
    mem_t        mdl_m;
    logic [31:0] mdl_a;
    int          mdl_nb;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    icache_assoc #(
        .LINE_WORDS (8),
        .SETS       (64),
        .WAYS       (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cache_ena (cache_ena),
        .flush     (flush),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_rdata   (s_rdata),
        .s_rvalid  (s_rvalid),
        .m_araddr  (m_araddr),
        .m_arvalid (m_arvalid),
        .m_arready (m_arready),
        .m_rdata   (m_rdata),
        .m_rvalid  (m_rvalid),
        .m_rlast   (m_rlast),
        .m_rready  (m_rready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual 0x%08h required 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor: every s_rvalid pulse must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (s_rvalid) begin
                if (rsp_q.size() == 0) begin
                    check("unexpected_rvalid", 32'(s_rvalid), 32'd0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    check("rdata", s_rdata, mon_r.data);
                    check("latency", 32'(cyc),
                          32'((mon_r.exp_cyc >= 0) ? mon_r.exp_cyc : rlast_cyc + 1));
                end
            end
        end
    end

    // Memory model: accepts AR one cycle late, then bursts address-valued beats.
    initial begin
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rdata   = '0;
        forever begin
            @(posedge clk); #1;
            if (m_arvalid && !rst) begin
                mdl_a = m_araddr;
                if (mem_q.size() == 0) begin
                    check("unexpected_ar", 32'(m_arvalid), 32'd0);
                    mdl_nb = LINE_WORDS;
                end else begin
                    mdl_m = mem_q.pop_front();
                    check("araddr", mdl_a, mdl_m.addr);
                    mdl_nb = mdl_m.beats;
                end
                @(posedge clk); #1;
                check("arvalid_hold", 32'(m_arvalid), 32'd1);
                check("araddr_hold", m_araddr, mdl_a);
                m_arready = 1'b1;
                @(posedge clk); #1;
                m_arready = 1'b0;
                for (int i = 0; i < mdl_nb; i++) begin
                    if (!m_rready) break;
                    m_rvalid = 1'b1;
                    m_rdata  = mdl_a + 32'(4 * i);
                    m_rlast  = (i == mdl_nb - 1);
                    mem_beat = i;
                    if (m_rlast) rlast_cyc = cyc;
                    @(posedge clk); #1;
                end
                m_rvalid = 1'b0;
                m_rlast  = 1'b0;
                mem_beat = -1;
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (rsp_q.size() == 0 && mem_q.size() == 0 && mem_beat < 0) break;
            @(posedge clk);
        end
        check("pending_after_timeout", 32'(rsp_q.size() + mem_q.size()), 32'd0);
        rsp_q.delete();
        mem_q.delete();
        @(posedge clk);
    endtask

    task automatic issue(input logic [31:0] addr);
        @(posedge clk); #1;
        s_araddr  = addr;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
    endtask

    // hit=1: no memory traffic, response two cycles after the request cycle.
    task automatic req(input logic [31:0] addr, input bit hit,
                       input logic [31:0] mem_addr, input int beats);
        rsp_t r;
        mem_t m;
        if (!hit) begin
            m.addr  = mem_addr;
            m.beats = beats;
            mem_q.push_back(m);
        end
        @(posedge clk); #1;
        r.data    = addr;
        r.exp_cyc = hit ? cyc + 2 : -1;
        rsp_q.push_back(r);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        wait_idle();
    endtask

    task automatic wait_beat(input int beat);
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #2;
            if (mem_beat == beat) break;
        end
        check("reach_beat", 32'(mem_beat), 32'(beat));
    endtask

    task automatic check_reset_outputs();
        check("rst_s_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_s_rdata", s_rdata, 32'd0);
        check("rst_m_arvalid", 32'(m_arvalid), 32'd0);
        check("rst_m_araddr", m_araddr, 32'd0);
        check("rst_m_rready", 32'(m_rready), 32'd0);
    endtask

    initial begin
        mem_t m;
        rst       = 1'b1;
        cache_ena = 1'b1;
        flush     = 1'b0;
        s_arvalid = 1'b0;
        s_araddr  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);

        // Cold miss, then hit within the line; next line of another set.
        req(32'h0000_0000, 1'b0, 32'h0000_0000, LINE_WORDS);
        req(32'h0000_0004, 1'b1, 32'h0, 0);
        req(32'h0000_0040, 1'b0, 32'h0000_0040, LINE_WORDS);
        req(32'h0000_0044, 1'b1, 32'h0, 0);

        // Three lines in set 0: third evicts 0x0 via round-robin.
        req(32'h0000_0800, 1'b0, 32'h0000_0800, LINE_WORDS);
        req(32'h0000_1000, 1'b0, 32'h0000_1000, LINE_WORDS);
        req(32'h0000_0800, 1'b1, 32'h0, 0);
        req(32'h0000_0000, 1'b0, 32'h0000_0000, LINE_WORDS);
        req(32'h0000_001C, 1'b1, 32'h0, 0);

        // Last set, non-zero word: line-aligned refill address, requested word returned.
        req(32'h0000_5FF8, 1'b0, 32'h0000_5FE0, LINE_WORDS);
        req(32'h0000_5FFC, 1'b1, 32'h0, 0);

        // Flush during beat 3: burst completes and installs, no response.
        m.addr  = 32'h0000_2000;
        m.beats = LINE_WORDS;
        mem_q.push_back(m);
        issue(32'h0000_2000);
        wait_beat(3);
        flush = 1'b1;
        @(posedge clk); #2;
        flush = 1'b0;
        wait_idle();
        req(32'h0000_2004, 1'b1, 32'h0, 0);

        // Flush with a request in IDLE drops it.
        @(posedge clk); #1;
        s_araddr  = 32'h0000_0080;
        s_arvalid = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        flush     = 1'b0;
        repeat (6) @(posedge clk);
        wait_idle();

        // Reset in the middle of a refill.
        m.addr  = 32'h0000_3000;
        m.beats = LINE_WORDS;
        mem_q.push_back(m);
        issue(32'h0000_3000);
        wait_beat(2);
        rst = 1'b1;
        @(posedge clk); #2;
        check_reset_outputs();
        @(posedge clk); #2;
        rst = 1'b0;
        wait_idle();
        req(32'h0000_3000, 1'b0, 32'h0000_3000, LINE_WORDS);
        req(32'h0000_301C, 1'b1, 32'h0, 0);

        // cache_ena=0: single-beat exact-address reads, nothing allocated.
        cache_ena = 1'b0;
        req(32'h0000_0000, 1'b0, 32'h0000_0000, 1);
        req(32'h0000_0000, 1'b0, 32'h0000_0000, 1);
        cache_ena = 1'b1;
        req(32'h0000_0000, 1'b0, 32'h0000_0000, LINE_WORDS);

`ifdef ICACHE_UNCACHED_EN
        req(32'hA000_0018, 1'b0, 32'hA000_0018, 1);
        req(32'hA000_0018, 1'b0, 32'hA000_0018, 1);
`else
        req(32'hA000_0018, 1'b0, 32'hA000_0000, LINE_WORDS);
        req(32'hA000_0018, 1'b1, 32'h0, 0);
`endif

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at cycle %0d, required completion earlier", cyc);
        $fatal(1);
    end

endmodule
